ram_mar_ctrl: RTL

- Parametrised memory-address register plus RAM on the shared tri-state system bus; successor to the fixed 16x8 RAM/MAR.
- Adds:
  - configurable width and depth
  - MAR auto-increment
  - combinational read drive
  - sequential clear-after-reset
  - a program-mode loader port with a four-phase req/ack handshake, used by the front-panel/loader to fill memory before run.

---
 rtl/ram_mar_pkg.sv | 23 ++
 rtl/ram_mar_prog_hs.sv | 65 ++++++
 rtl/ram_mar_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ram_mar_pkg.sv
// ram_mar_pkg: shared definitions for the RAM/MAR block.
//   state_t      top-level sequencing states (clear / run / loader handshake)
//   DEF_*        default bus and address widths
//   even_parity  even-parity bit of a word (zero-extended to PAR_MAX_WIDTH)
package ram_mar_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int PAR_MAX_WIDTH  = 64;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_RUN       = 2'd1,
    ST_PROG_IDLE = 2'd2,
    ST_PROG_ACK  = 2'd3
  } state_t;

  // Zero-extension does not change parity, so one fixed width serves all words.
  function automatic logic even_parity(input logic [PAR_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_mar_prog_hs.sv
// ram_mar_prog_hs: four-phase req/ack handshake used by the loader to fill
// memory while the block is in program mode.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_RUN       | handshake inactive, top is running (or clearing)
//   ST_PROG_IDLE | program mode, waiting for prog_req
//   ST_PROG_ACK  | word written, prog_ack high until prog_req drops
//
// Ports:
//   clock, reset_n  clock / async active-low reset
//   i_enter         top is in RUN and sampled prog_mode
//   i_prog_mode     loader mode request
//   i_prog_req      loader write request
//   o_active        in PROG_IDLE or PROG_ACK
//   o_prog_ack      handshake acknowledge (decoded from the state register)
//   o_wr_stb        write prog_data into mem[prog_addr] this edge
//   o_exit          leaving program mode this edge
module ram_mar_prog_hs
  import ram_mar_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic i_enter,
  input  logic i_prog_mode,
  input  logic i_prog_req,
  output logic o_active,
  output logic o_prog_ack,
  output logic o_wr_stb,
  output logic o_exit
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PROG_IDLE: begin
        if (i_prog_req)        w_next = ST_PROG_ACK;
        else if (!i_prog_mode) w_next = ST_RUN;
      end
      // prog_mode is not looked at here: a drop waits for the handshake to finish
      ST_PROG_ACK: begin
        if (!i_prog_req) w_next = ST_PROG_IDLE;
      end
      default: begin
        if (i_enter) w_next = ST_PROG_IDLE;
      end
    endcase
  end

  always_comb begin
    o_active   = (r_state == ST_PROG_IDLE) || (r_state == ST_PROG_ACK);
    o_prog_ack = (r_state == ST_PROG_ACK);
    o_wr_stb   = (r_state == ST_PROG_IDLE) && i_prog_req;
    o_exit     = (r_state == ST_PROG_IDLE) && !i_prog_req && !i_prog_mode;
  end

endmodule

// File: rtl/ram_mar_ctrl.sv
// ram_mar_ctrl: parametrised memory-address register + RAM on the shared
// tri-state system bus, with clear-after-reset and a loader port.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | zeroing one word per cycle, busy high
//   ST_RUN   | bus controls active, unless the handshake block is in PROG
//
// Optional feature: define RAM_MAR_PARITY_EN to store an even-parity bit per
// word and flag parity_err on a mismatching read; otherwise parity_err is 0.
//
// Ports:
//   clock, reset_n          clock / async active-low reset
//   mar_in, mar_inc         load MAR from bus / increment MAR
//   ram_in, ram_out         write bus to mem[mar_addr] / drive mem[mar_addr]
//   prog_mode, prog_req     loader mode and four-phase write request
//   prog_addr, prog_data    loader write address and data
//   prog_ack                loader acknowledge
//   busy, in_prog           clearing / in program mode
//   ctrl_err, parity_err    one-cycle error pulses
//   mar_addr                current MAR
//   bus                     shared tri-state system bus
module ram_mar_ctrl
  import ram_mar_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mar_in,
  input  logic                  mar_inc,
  input  logic                  ram_in,
  input  logic                  ram_out,
  input  logic                  prog_mode,
  input  logic                  prog_req,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_ack,
  output logic                  busy,
  output logic                  in_prog,
  output logic                  ctrl_err,
  output logic                  parity_err,
  output logic [ADDR_WIDTH-1:0] mar_addr,
  inout  wire  [DATA_WIDTH-1:0] bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_ctrl_err;

  logic                  w_hs_active;
  logic                  w_hs_wr;
  logic                  w_hs_exit;
  logic                  w_run;
  logic                  w_enter;
  logic                  w_drive;
  logic                  w_conflict;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  ram_mar_prog_hs u_prog_hs (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_enter     (w_enter),
    .i_prog_mode (prog_mode),
    .i_prog_req  (prog_req),
    .o_active    (w_hs_active),
    .o_prog_ack  (prog_ack),
    .o_wr_stb    (w_hs_wr),
    .o_exit      (w_hs_exit)
  );

  assign w_run      = (r_state == ST_RUN) && !w_hs_active;
  assign w_enter    = w_run && prog_mode;
  assign w_conflict = w_run && ram_out && (ram_in || mar_in);
  // reset_n gates the driver so the bus floats during reset even when CLEAR is skipped
  assign w_drive    = w_run && ram_out && !ram_in && !mar_in && reset_n;

  assign bus = w_drive ? r_mem[r_mar] : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_ptr == LAST_ADDR) w_next = ST_RUN;
      default:  w_next = r_state;
    endcase
  end

  always_comb begin
    busy    = (r_state == ST_CLEAR);
    in_prog = w_hs_active;
    w_we    = 1'b0;
    w_waddr = r_mar;
    w_wdata = bus;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_ptr;
      w_wdata = '0;
    end else if (w_hs_active) begin
      w_we    = w_hs_wr;
      w_waddr = prog_addr;
      w_wdata = prog_data;
    end else begin
      w_we    = ram_in && !ram_out;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                r_clr_ptr <= '0;
    else if (r_state == ST_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
  end

  // The MAR update uses the pre-edge value for the write address, so a
  // write and an increment in the same cycle land at the old address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mar <= '0;
    end else if (w_hs_exit) begin
      r_mar <= '0;
    end else if (w_run) begin
      if (mar_in && !ram_out) r_mar <= bus[ADDR_WIDTH-1:0];
      else if (mar_inc)       r_mar <= r_mar + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_ctrl_err <= 1'b0;
    else          r_ctrl_err <= w_conflict;
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign ctrl_err = r_ctrl_err;
  assign mar_addr = r_mar;

`ifdef RAM_MAR_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_err;

  always_ff @(posedge clock) begin
    if (w_we) r_par[w_waddr] <= even_parity(PAR_MAX_WIDTH'(w_wdata));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_parity_err <= 1'b0;
    else          r_parity_err <= w_drive &&
                    (even_parity(PAR_MAX_WIDTH'(r_mem[r_mar])) != r_par[r_mar]);
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
